// File: rtl/compute_job_dispatcher.sv
// Queued multi-channel job dispatcher: buffers op descriptors in a small FIFO, launches them one at a
// time on NUM_CH executors, muxes the shared BRAM read port and guards each job with a watchdog.
module compute_job_dispatcher #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int OP_WIDTH       = 3,
  parameter int NUM_CH         = 2,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W         = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         abort,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [CH_W-1:0]              job_ch,
  input  logic [OP_WIDTH-1:0]          job_op,
  input  logic [2:0]                   job_matrix_a,
  input  logic [2:0]                   job_matrix_b,
  input  logic [DATA_WIDTH-1:0]        job_scalar,
  input  logic [ADDR_WIDTH-1:0]        sel_bram_addr,
  output logic [NUM_CH-1:0]            exec_start,
  output logic [OP_WIDTH-1:0]          exec_op,
  output logic [2:0]                   exec_matrix_a,
  output logic [2:0]                   exec_matrix_b,
  output logic [DATA_WIDTH-1:0]        exec_scalar,
  input  logic [NUM_CH-1:0]            exec_done,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] exec_bram_addr,
  output logic [ADDR_WIDTH-1:0]        bram_rd_addr,
  output logic                         busy,
  output logic                         done_pulse,
  output logic                         error,
  output logic [1:0]                   err_code,
  output logic [LVL_W-1:0]             queue_level,
  output logic [15:0]                  jobs_done
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RETIRE,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [OP_WIDTH-1:0]   op;
    logic [2:0]            matrix_a;
    logic [2:0]            matrix_b;
    logic [DATA_WIDTH-1:0] scalar;
  } desc_t;

  state_t state_reg, state_next;

  desc_t             fifo_mem [QUEUE_DEPTH];
  desc_t             push_desc;
  desc_t             head;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  count_reg;
  logic [CH_W-1:0]   active_ch_reg;
  logic [TMR_W-1:0]  timer_reg;

  logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
  logic [NUM_CH-1:0]     ch_hit;

  logic full, empty, ch_bad, push_ok, push_bad, pop, flush;
  logic launch_now, done_act, timeout_hit, enter_error;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_addr[gi] = exec_bram_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign ch_hit[gi]  = (active_ch_reg == CH_W'(gi));
  end

  assign full      = (count_reg == LVL_W'(QUEUE_DEPTH));
  assign empty     = (count_reg == '0);
  assign job_ready = !full && (state_reg != S_ERROR) && !abort;
  assign ch_bad    = (int'(job_ch) >= NUM_CH);
  assign push_ok   = job_valid && job_ready && !ch_bad;
  assign push_bad  = job_valid && job_ready && ch_bad;
  assign pop       = (state_reg == S_IDLE) && !empty && !abort;

  assign push_desc = '{ch: job_ch, op: job_op, matrix_a: job_matrix_a,
                       matrix_b: job_matrix_b, scalar: job_scalar};
  assign head      = fifo_mem[rd_ptr_reg];

  // A done pulse from any channel other than the one running is ignored here.
  assign done_act    = (state_reg == S_RUN) && |(exec_done & ch_hit);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_reg == TMR_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (!empty) state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_RUN;
      S_RUN: begin
        if (done_act)         state_next = S_RETIRE;
        else if (timeout_hit) state_next = S_ERROR;
      end
      S_RETIRE: state_next = S_IDLE;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_IDLE;
    endcase
    if (push_bad) state_next = S_ERROR;
    if (abort)    state_next = S_IDLE;
  end

  assign enter_error = (state_next == S_ERROR) && (state_reg != S_ERROR);
  // The queue is emptied on abort and held empty for as long as we sit in (or enter) ERROR.
  assign flush       = abort || (state_next == S_ERROR);

  assign launch_now   = (state_reg == S_LAUNCH) && !abort;
  assign exec_start   = launch_now ? ch_hit : '0;
  assign done_pulse   = (state_reg == S_RETIRE) && !abort;
  assign error        = (state_reg == S_ERROR);
  assign busy         = (state_reg == S_LAUNCH) || (state_reg == S_RUN) ||
                        (state_reg == S_RETIRE) || !empty;
  assign bram_rd_addr = (state_reg == S_RUN) ? ch_addr[active_ch_reg] : sel_bram_addr;
  assign queue_level  = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Descriptor storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= push_desc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      active_ch_reg <= '0;
      exec_op       <= '0;
      exec_matrix_a <= '0;
      exec_matrix_b <= '0;
      exec_scalar   <= '0;
      timer_reg     <= '0;
      err_code      <= '0;
      jobs_done     <= '0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + LVL_W'(push_ok) - LVL_W'(pop);
      end

      if (pop) begin
        active_ch_reg <= head.ch;
        exec_op       <= head.op;
        exec_matrix_a <= head.matrix_a;
        exec_matrix_b <= head.matrix_b;
        exec_scalar   <= head.scalar;
      end

      if (state_reg == S_LAUNCH) begin
        timer_reg <= '0;
      end else if (state_reg == S_RUN) begin
        timer_reg <= timer_reg + TMR_W'(1);
      end

      if (abort) begin
        err_code <= 2'd0;
      end else if (enter_error) begin
        err_code <= push_bad ? 2'd2 : 2'd1;
      end

      if (done_pulse && (jobs_done != 16'hFFFF)) begin
        jobs_done <= jobs_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_compute_job_dispatcher.sv
// Scoreboard bench for compute_job_dispatcher: expected launches are queued at push time and a
// monitor compares them against each exec_start; directed checks cover timing, errors and abort.
module tb_compute_job_dispatcher;

  localparam int DW  = 32;
  localparam int AW  = 14;
  localparam int OW  = 3;
  localparam int NCH = 3;
  localparam int QD  = 4;
  localparam int TO  = 16;
  localparam int CHW = 2;
  localparam int LVW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            abort = 1'b0;
  logic            job_valid = 1'b0;
  logic            job_ready;
  logic [CHW-1:0]  job_ch = '0;
  logic [OW-1:0]   job_op = '0;
  logic [2:0]      job_matrix_a = '0;
  logic [2:0]      job_matrix_b = '0;
  logic [DW-1:0]   job_scalar = '0;
  logic [AW-1:0]   sel_bram_addr = '0;
  logic [NCH-1:0]  exec_start;
  logic [OW-1:0]   exec_op;
  logic [2:0]      exec_matrix_a;
  logic [2:0]      exec_matrix_b;
  logic [DW-1:0]   exec_scalar;
  logic [NCH-1:0]  exec_done;
  logic [NCH-1:0]  exec_done_model = '0;
  logic [NCH-1:0]  exec_done_extra = '0;
  logic [NCH*AW-1:0] exec_bram_addr = '0;
  logic [AW-1:0]   bram_rd_addr;
  logic            busy;
  logic            done_pulse;
  logic            error;
  logic [1:0]      err_code;
  logic [LVW-1:0]  queue_level;
  logic [15:0]     jobs_done;

  assign exec_done = exec_done_model | exec_done_extra;

  compute_job_dispatcher #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW), .NUM_CH(NCH),
    .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .job_valid(job_valid), .job_ready(job_ready), .job_ch(job_ch), .job_op(job_op),
    .job_matrix_a(job_matrix_a), .job_matrix_b(job_matrix_b), .job_scalar(job_scalar),
    .sel_bram_addr(sel_bram_addr),
    .exec_start(exec_start), .exec_op(exec_op), .exec_matrix_a(exec_matrix_a),
    .exec_matrix_b(exec_matrix_b), .exec_scalar(exec_scalar),
    .exec_done(exec_done), .exec_bram_addr(exec_bram_addr),
    .bram_rd_addr(bram_rd_addr), .busy(busy), .done_pulse(done_pulse),
    .error(error), .err_code(err_code), .queue_level(queue_level), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CHW-1:0] ch;
    logic [OW-1:0]  op;
    logic [2:0]     a;
    logic [2:0]     b;
    logic [DW-1:0]  s;
  } exp_t;

  exp_t launch_q[$];
  exp_t mon_e;
  logic [NCH-1:0] mon_onehot;
  bit   mon_outstanding;
  int   errors;
  int   checks;
  int   done_seen;
  int   exec_lat;
  int   addr_ctr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Distinct, changing addresses on every channel and on the selector port.
  initial begin
    addr_ctr = 0;
    forever begin
      @(posedge clk);
      #1;
      addr_ctr++;
      sel_bram_addr  = AW'(addr_ctr * 5 + 1);
      exec_bram_addr = {AW'(addr_ctr + 3000), AW'(addr_ctr + 2000), AW'(addr_ctr + 1000)};
    end
  end

  // Executor model: answers a start with a done pulse exec_lat cycles later (0 = never).
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && exec_start != '0 && exec_lat > 0) begin
        int lat;
        logic [NCH-1:0] m;
        m   = exec_start;
        lat = exec_lat;
        repeat (lat) @(posedge clk);
        #1 exec_done_model = m;
        @(posedge clk);
        #1 exec_done_model = '0;
      end
    end
  end

  // Monitor: pops the expected launch on every exec_start, counts retirements.
  initial begin
    mon_outstanding = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_outstanding = 1'b0;
      end else begin
        if (exec_start != '0) begin
          $display("launch start=%b op=%0d a=%0d b=%0d scalar=0x%0h",
                   exec_start, exec_op, exec_matrix_a, exec_matrix_b, exec_scalar);
          check("no_overlap", 64'(mon_outstanding), 0);
          if (launch_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_launch: got start=%b expected none at %0t", exec_start, $time);
          end else begin
            mon_e = launch_q.pop_front();
            mon_onehot = NCH'(1) << mon_e.ch;
            check("launch_start", exec_start, mon_onehot);
            check("launch_op", exec_op, mon_e.op);
            check("launch_a", exec_matrix_a, mon_e.a);
            check("launch_b", exec_matrix_b, mon_e.b);
            check("launch_scalar", exec_scalar, mon_e.s);
          end
          mon_outstanding = 1'b1;
        end
        if (done_pulse) begin
          done_seen++;
          $display("retire jobs_done_before=%0d", jobs_done);
          mon_outstanding = 1'b0;
        end
        if (!busy || error) mon_outstanding = 1'b0;
        if (!error && !abort) check("ready_vs_level", 64'(job_ready), 64'(queue_level != LVW'(QD)));
      end
    end
  end

  task automatic push_job(input logic [CHW-1:0] ch, input logic [OW-1:0] op,
                          input logic [2:0] a, input logic [2:0] b,
                          input logic [DW-1:0] s, input bit expect_launch);
    int n = 0;
    job_valid = 1'b1;
    job_ch = ch;
    job_op = op;
    job_matrix_a = a;
    job_matrix_b = b;
    job_scalar = s;
    if (expect_launch) launch_q.push_back('{ch, op, a, b, s});
    $display("push ch=%0d op=%0d a=%0d b=%0d scalar=0x%0h", ch, op, a, b, s);
    @(negedge clk);
    while (!job_ready && n < 50) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n++;
    end
    check("push_accepted", 64'(job_ready), 1);
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_launch(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exec_start == '0 && n < 100);
    check("launch_seen", 64'(exec_start != '0), 1);
  endtask

  task automatic wait_done_count(input int target);
    int n = 0;
    while (done_seen < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_seen, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    errors = 0;
    checks = 0;
    done_seen = 0;
    exec_lat = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", exec_start, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_level", queue_level, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_done_pulse", done_pulse, 0);
    check("rst_exec_op", exec_op, 0);
    check("rst_bram", bram_rd_addr, sel_bram_addr);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single job on ch0, executor done 10 cycles after start
    exec_lat = 10;
    push_job(2'd0, 3'd2, 3'd1, 3'd3, 32'd5, 1'b1);
    @(negedge clk);
    check("t1_start_early", exec_start, 0);
    check("t1_level", queue_level, 1);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_start", exec_start, 3'b001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_pulse && n < 100);
    check("t1_latency", n, 11);
    @(negedge clk);
    check("t1_single_done", done_pulse, 0);
    check("t1_jobs_done", jobs_done, 1);
    check("t1_op_held", exec_op, 2);
    check("t1_a_held", exec_matrix_a, 1);
    check("t1_b_held", exec_matrix_b, 3);
    check("t1_scalar_held", exec_scalar, 5);
    check("t1_idle", busy, 0);

    // Six back-to-back jobs alternating ch0/ch1; the queue fills to 4 behind the first
    @(posedge clk);
    #1 exec_lat = 6;
    for (int i = 0; i < 6; i++) begin
      push_job(CHW'(i % 2), OW'(i + 1), 3'(i), 3'(7 - i), 32'h100 + 32'(i), 1'b1);
    end
    wait_done_count(7);
    repeat (2) @(negedge clk);
    check("t2_jobs_done", jobs_done, 7);
    check("t2_level", queue_level, 0);
    check("t2_idle", busy, 0);

    // BRAM mux: selector in IDLE, ch1 address during RUN; stray ch0 done ignored
    @(posedge clk);
    #1 exec_lat = 8;
    @(negedge clk);
    check("t3_idle_addr", bram_rd_addr, sel_bram_addr);
    @(posedge clk);
    #1 exec_done_extra = 3'b001;
    @(negedge clk);
    check("t3_idle_addr2", bram_rd_addr, sel_bram_addr);
    @(posedge clk);
    #1 exec_done_extra = 3'b000;
    @(negedge clk);
    check("t3_idle_done_ignored", done_pulse, 0);
    check("t3_idle_busy", busy, 0);
    check("t3_idle_jobs", jobs_done, 7);
    @(posedge clk);
    #1;
    push_job(2'd1, 3'd5, 3'd2, 3'd6, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t3_start", exec_start, 3'b010);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 exec_done_extra = (k == 1) ? 3'b001 : 3'b000;
      @(negedge clk);
      check("t3_run_addr", bram_rd_addr, exec_bram_addr[AW +: AW]);
      check("t3_no_retire", done_pulse, 0);
    end
    @(posedge clk);
    #1 exec_done_extra = 3'b000;
    wait_done_count(8);
    repeat (2) @(negedge clk);
    check("t3_jobs_done", jobs_done, 8);

    // Abort in the same cycle as exec_done with two jobs queued
    @(posedge clk);
    #1 exec_lat = 0;
    push_job(2'd0, 3'd3, 3'd4, 3'd5, 32'hA5A5, 1'b1);
    push_job(2'd1, 3'd1, 3'd1, 3'd1, 32'd1, 1'b0);
    push_job(2'd0, 3'd6, 3'd2, 3'd2, 32'd2, 1'b0);
    @(negedge clk);
    check("t4_level", queue_level, 2);
    check("t4_busy", busy, 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    exec_done_extra = 3'b001;
    @(negedge clk);
    check("t4_ready_abort", job_ready, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    exec_done_extra = 3'b000;
    @(negedge clk);
    check("t4_no_done", done_pulse, 0);
    check("t4_level_flushed", queue_level, 0);
    check("t4_idle", busy, 0);
    check("t4_error", error, 0);
    check("t4_jobs_kept", jobs_done, 8);
    repeat (5) @(negedge clk);
    check("t4_still_idle", busy, 0);

    // Watchdog: executor never answers
    @(posedge clk);
    #1;
    push_job(2'd2, 3'd7, 3'd5, 3'd4, 32'h77, 1'b1);
    wait_launch(n);
    check("t5_launch_delay", n, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!error && n < 40);
    check("t5_timeout_cycles", n, 17);
    check("t5_err_code", err_code, 1);
    check("t5_ready", job_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_start", exec_start, 0);
    @(posedge clk);
    #1;
    job_valid = 1'b1;
    job_ch = 2'd0;
    repeat (3) begin
      @(negedge clk);
      check("t5_err_ready", job_ready, 0);
      check("t5_err_level", queue_level, 0);
    end
    @(posedge clk);
    #1;
    abort = 1'b1;
    job_valid = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t5_cleared", error, 0);
    check("t5_code_cleared", err_code, 0);
    check("t5_ready_back", job_ready, 1);

    // Bad channel: descriptor dropped, ERROR with code 2
    @(posedge clk);
    #1;
    push_job(2'd3, 3'd1, 3'd1, 3'd1, 32'h33, 1'b0);
    @(negedge clk);
    check("t6_error", error, 1);
    check("t6_err_code", err_code, 2);
    check("t6_level", queue_level, 0);
    check("t6_ready", job_ready, 0);
    @(posedge clk);
    #1;
    job_valid = 1'b1;
    job_ch = 2'd1;
    repeat (3) begin
      @(negedge clk);
      check("t6_not_accepted", job_ready, 0);
      check("t6_err_level", queue_level, 0);
    end
    @(posedge clk);
    #1;
    abort = 1'b1;
    job_valid = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t6_cleared", error, 0);

    // Asynchronous reset in the middle of RUN with a job queued behind
    @(posedge clk);
    #1;
    push_job(2'd0, 3'd4, 3'd3, 3'd2, 32'h1234, 1'b1);
    wait_launch(n);
    @(posedge clk);
    #1;
    push_job(2'd1, 3'd2, 3'd2, 3'd2, 32'h55, 1'b0);
    @(negedge clk);
    check("t7_level_before", queue_level, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_busy", busy, 0);
    check("t7_level", queue_level, 0);
    check("t7_jobs_done", jobs_done, 0);
    check("t7_start", exec_start, 0);
    check("t7_exec_op", exec_op, 0);
    check("t7_exec_scalar", exec_scalar, 0);
    check("t7_error", error, 0);
    check("t7_done_pulse", done_pulse, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_stays_idle", busy, 0);
    check("scoreboard_drained", launch_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
